// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared FPU definitions.
//   Float format constants (bias, all-ones exponent, quiet NaN) derived from
//   the exponent and mantissa widths, the rounding-mode encoding, the
//   accrued-exception flag pair, and the float-to-int converter state and
//   debug types.
package fpu_pkg;

  localparam int FP_BITS      = 32;
  localparam int FP_MANT_BITS = 23;
  localparam int FP_EXP_BITS  = 8;

  localparam int FP_BIAS = (1 << (FP_EXP_BITS - 1)) - 1;
  localparam logic [FP_EXP_BITS-1:0] FP_EXP_INF = '1;
  localparam logic [FP_BITS-1:0] FP_QNAN =
    {1'b0, FP_EXP_INF, 1'b1, {(FP_MANT_BITS - 1){1'b0}}};

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Packs as {nv, nx}, the bit order of the o_flags port.
  typedef struct packed {
    logic nv;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    CVT_IDLE,
    CVT_SHIFT,
    CVT_ROUND,
    CVT_DONE
  } cvt_state_e;

  // Converter state and the rounding mode latched with the current request.
  typedef struct packed {
    cvt_state_e state;
    logic [2:0] rm;
  } cvt_dbg_t;

endpackage

// File: rtl/fpu_cvt_f2i_if.sv
// fpu_cvt_f2i_if -- request/response bundle of the float-to-int converter.
//   Request : i_valid, o_ready, i_x (BITS), i_signed, i_rm[2:0]
//   Response: o_valid, i_ready, o_result (XLEN), o_flags {NV, NX}
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low; the consumer may change ready at any time.
// Modport slave is the converter side, master the requester/consumer side.
interface fpu_cvt_f2i_if #(
  parameter int BITS = 32,
  parameter int XLEN = 32
);

  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] i_x;
  logic            i_signed;
  logic [2:0]      i_rm;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [1:0]      o_flags;

  modport slave (
    input  i_valid, i_x, i_signed, i_rm, i_ready,
    output o_ready, o_valid, o_result, o_flags
  );

  modport master (
    output i_valid, i_x, i_signed, i_rm, i_ready,
    input  o_ready, o_valid, o_result, o_flags
  );

endinterface

// File: rtl/fpu_classify.sv
// fpu_classify -- combinational IEEE-754 operand classifier.
//   x        in  BITS             float word
//   isNan    out 1                exponent all ones, mantissa non-zero
//   isInf    out 1                exponent all ones, mantissa zero
//   isZero   out 1                +0 or -0
//   isDenorm out 1                exponent zero, mantissa non-zero
//   sign     out 1                sign bit
//   expUnb   out EXPONENT_BITS+2  unbiased exponent, signed (1-bias for denormals)
//   sig      out MANTISSA_BITS+1  significand including the hidden bit
module fpu_classify
  import fpu_pkg::*;
#(
  parameter int BITS          = FP_BITS,
  parameter int MANTISSA_BITS = FP_MANT_BITS,
  parameter int EXPONENT_BITS = FP_EXP_BITS
) (
  input  logic [BITS-1:0]                 x,
  output logic                            isNan,
  output logic                            isInf,
  output logic                            isZero,
  output logic                            isDenorm,
  output logic                            sign,
  output logic signed [EXPONENT_BITS+1:0] expUnb,
  output logic [MANTISSA_BITS:0]          sig
);

  localparam int EXP_W = EXPONENT_BITS + 2;
  localparam logic signed [EXP_W-1:0] BIAS_S = EXP_W'((1 << (EXPONENT_BITS - 1)) - 1);

  logic [EXPONENT_BITS-1:0] expField;
  logic [MANTISSA_BITS-1:0] man;
  logic                     expMax;
  logic                     expMin;
  logic                     manZero;

  assign sign     = x[BITS-1];
  assign expField = x[BITS-2 -: EXPONENT_BITS];
  assign man      = x[MANTISSA_BITS-1:0];

  assign expMax  = &expField;
  assign expMin  = ~|expField;
  assign manZero = ~|man;

  assign isNan    = expMax & ~manZero;
  assign isInf    = expMax & manZero;
  assign isZero   = expMin & manZero;
  assign isDenorm = expMin & ~manZero;

  // Denormals share the smallest normal exponent but have no hidden one.
  assign sig    = {~expMin, man};
  assign expUnb = expMin ? ($signed(EXP_W'(1)) - BIAS_S)
                         : ($signed({2'b00, expField}) - BIAS_S);

endmodule

// File: rtl/fpu_cvt_f2i.sv
// fpu_cvt_f2i -- sequential float-to-integer converter (FCVT.W.S / FCVT.WU.S).
//   i_clk    in   clock, all state on the rising edge
//   i_rst_n  in   asynchronous active-low reset
//   bus      --   fpu_cvt_f2i_if.slave: i_valid/o_ready/i_x/i_signed/i_rm
//                 request, o_valid/i_ready/o_result/o_flags {NV,NX} response
//   dbg      out  current state and latched rounding mode
// The significand is aligned one bit per cycle (left for large exponents,
// right with guard/sticky capture otherwise), then rounded and saturated.
// Build option: FPU_CVT_RM_EN defined decodes i_rm (RNE/RTZ/RDN/RUP/RMM,
// reserved codes act as RTZ); undefined, every conversion rounds toward zero.
module fpu_cvt_f2i
  import fpu_pkg::*;
#(
  parameter int BITS          = FP_BITS,
  parameter int MANTISSA_BITS = FP_MANT_BITS,
  parameter int EXPONENT_BITS = FP_EXP_BITS,
  parameter int XLEN          = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fpu_cvt_f2i_if.slave    bus,
  output cvt_dbg_t        dbg
);

  localparam int CNT_W = $clog2(XLEN + MANTISSA_BITS + 1);
  localparam int RSHIFT_MAX = MANTISSA_BITS + 2;
  localparam logic [XLEN-1:0] SAT_POS_S = {1'b0, {(XLEN - 1){1'b1}}};
  localparam logic [XLEN-1:0] SAT_NEG_S = {1'b1, {(XLEN - 1){1'b0}}};
  localparam logic [XLEN:0]   LIM_POS_S = {2'b00, {(XLEN - 1){1'b1}}};
  localparam logic [XLEN:0]   LIM_NEG_S = {2'b01, {(XLEN - 1){1'b0}}};

  cvt_state_e       stateQ, stateD;
  logic [XLEN-1:0]  magQ, magD;
  logic             guardQ, guardD;
  logic             stickyQ, stickyD;
  logic [CNT_W-1:0] countQ, countD;
  logic             leftQ, leftD;
  logic             signQ, signD;
  logic             isSignedQ, isSignedD;
  logic [2:0]       rmQ, rmD;
  logic [XLEN-1:0]  resultQ, resultD;
  fflags_t          flagsQ, flagsD;

  logic                            cNan, cInf, cZero, cDenorm, cSign;
  logic signed [EXPONENT_BITS+1:0] cExp;
  logic [MANTISSA_BITS:0]          cSig;
  logic signed [31:0]              eInt;
  logic signed [31:0]              rightN;

  rm_e             rmEff;
  logic            inc;
  logic [XLEN:0]   rounded;
  logic            ovf;

  fpu_classify #(
    .BITS          (BITS),
    .MANTISSA_BITS (MANTISSA_BITS),
    .EXPONENT_BITS (EXPONENT_BITS)
  ) uClassify (
    .x        (bus.i_x),
    .isNan    (cNan),
    .isInf    (cInf),
    .isZero   (cZero),
    .isDenorm (cDenorm),
    .sign     (cSign),
    .expUnb   (cExp),
    .sig      (cSig)
  );

  assign eInt   = 32'(cExp);
  assign rightN = MANTISSA_BITS - eInt;

  // Saturation value for an unrepresentable result, chosen by its sign.
  function automatic logic [XLEN-1:0] satValue(input logic neg, input logic isSigned);
    if (neg) return isSigned ? SAT_NEG_S : '0;
    else     return isSigned ? SAT_POS_S : '1;
  endfunction

`ifdef FPU_CVT_RM_EN
  always_comb rmEff = (rmQ > 3'(RM_RMM)) ? RM_RTZ : rm_e'(rmQ);
`else
  always_comb rmEff = RM_RTZ;
`endif

  // Rounding increment and range check on the aligned magnitude.
  always_comb begin
    inc = 1'b0;
    unique case (rmEff)
      RM_RNE:  inc = guardQ & (magQ[0] | stickyQ);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = signQ & (guardQ | stickyQ);
      RM_RUP:  inc = ~signQ & (guardQ | stickyQ);
      RM_RMM:  inc = guardQ;
      default: inc = 1'b0;
    endcase
    rounded = {1'b0, magQ} + {{XLEN{1'b0}}, inc};
    if (isSignedQ) ovf = signQ ? (rounded > LIM_NEG_S) : (rounded > LIM_POS_S);
    else           ovf = signQ ? (|rounded) : rounded[XLEN];
  end

  always_comb begin
    stateD    = stateQ;
    magD      = magQ;
    guardD    = guardQ;
    stickyD   = stickyQ;
    countD    = countQ;
    leftD     = leftQ;
    signD     = signQ;
    isSignedD = isSignedQ;
    rmD       = rmQ;
    resultD   = resultQ;
    flagsD    = flagsQ;
    unique case (stateQ)
      CVT_IDLE: begin
        if (bus.i_valid) begin
          signD     = cSign;
          isSignedD = bus.i_signed;
          rmD       = bus.i_rm;
          if (cNan) begin
            // NaN always saturates positive regardless of its sign bit.
            resultD = satValue(1'b0, bus.i_signed);
            flagsD  = '{nv: 1'b1, nx: 1'b0};
            stateD  = CVT_DONE;
          end else if (cInf || (eInt > XLEN - 1)) begin
            resultD = satValue(cSign, bus.i_signed);
            flagsD  = '{nv: 1'b1, nx: 1'b0};
            stateD  = CVT_DONE;
          end else if (cZero) begin
            magD    = '0;
            guardD  = 1'b0;
            stickyD = 1'b0;
            countD  = '0;
            stateD  = CVT_ROUND;
          end else begin
            magD    = XLEN'(cSig);
            guardD  = 1'b0;
            stickyD = 1'b0;
            if (eInt >= MANTISSA_BITS) begin
              leftD  = 1'b1;
              countD = CNT_W'(eInt - MANTISSA_BITS);
            end else begin
              // Past MANTISSA_BITS+2 positions every bit lands in sticky
              // anyway, so the shift is capped there.
              leftD  = 1'b0;
              countD = (cDenorm || (rightN > RSHIFT_MAX)) ? CNT_W'(RSHIFT_MAX)
                                                         : CNT_W'(rightN);
            end
            stateD = (countD == '0) ? CVT_ROUND : CVT_SHIFT;
          end
        end
      end
      CVT_SHIFT: begin
        if (leftQ) begin
          magD = {magQ[XLEN-2:0], 1'b0};
        end else begin
          magD    = {1'b0, magQ[XLEN-1:1]};
          guardD  = magQ[0];
          stickyD = stickyQ | guardQ;
        end
        countD = countQ - CNT_W'(1);
        if (countQ == CNT_W'(1)) stateD = CVT_ROUND;
      end
      CVT_ROUND: begin
        if (ovf) begin
          resultD = satValue(signQ, isSignedQ);
          flagsD  = '{nv: 1'b1, nx: 1'b0};
        end else begin
          resultD = signQ ? (~rounded[XLEN-1:0] + XLEN'(1)) : rounded[XLEN-1:0];
          flagsD  = '{nv: 1'b0, nx: guardQ | stickyQ};
        end
        stateD = CVT_DONE;
      end
      CVT_DONE: begin
        if (bus.i_ready) stateD = CVT_IDLE;
      end
      default: stateD = CVT_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stateQ    <= CVT_IDLE;
      magQ      <= '0;
      guardQ    <= 1'b0;
      stickyQ   <= 1'b0;
      countQ    <= '0;
      leftQ     <= 1'b0;
      signQ     <= 1'b0;
      isSignedQ <= 1'b0;
      rmQ       <= '0;
      resultQ   <= '0;
      flagsQ    <= '0;
    end else begin
      stateQ    <= stateD;
      magQ      <= magD;
      guardQ    <= guardD;
      stickyQ   <= stickyD;
      countQ    <= countD;
      leftQ     <= leftD;
      signQ     <= signD;
      isSignedQ <= isSignedD;
      rmQ       <= rmD;
      resultQ   <= resultD;
      flagsQ    <= flagsD;
    end
  end

  assign bus.o_ready  = (stateQ == CVT_IDLE);
  assign bus.o_valid  = (stateQ == CVT_DONE);
  assign bus.o_result = resultQ;
  assign bus.o_flags  = flagsQ;
  assign dbg          = '{state: stateQ, rm: rmQ};

endmodule

// File: tb/tb_fpu_cvt_f2i.sv
// tb_fpu_cvt_f2i -- self-checking bench for fpu_cvt_f2i.
//   Directed vectors with known answers, a mid-conversion reset, then
//   randomized operands checked against an exact-arithmetic reference model.
module tb_fpu_cvt_f2i;
  import fpu_pkg::*;

`ifdef FPU_CVT_RM_EN
  localparam bit RM_EN = 1'b1;
`else
  localparam bit RM_EN = 1'b0;
`endif

  logic     i_clk = 1'b0;
  logic     i_rst_n = 1'b0;
  cvt_dbg_t dbg;

  fpu_cvt_f2i_if #(.BITS(32), .XLEN(32)) bus ();

  fpu_cvt_f2i #(
    .BITS          (32),
    .MANTISSA_BITS (23),
    .EXPONENT_BITS (8),
    .XLEN          (32)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave),
    .dbg     (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int nCompared = 0;
  int nMismatch = 0;
  logic [33:0] exp_q[$];  // {result, flags}

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model: exact integer/remainder arithmetic on the real value.
  function automatic void refModel(input logic [31:0] x, input bit sgn, input logic [2:0] rm,
                                   output logic [31:0] res, output logic [1:0] flg,
                                   output int lat);
    bit neg;
    int ex, sh, n, cmp;
    longint unsigned sig, ip, rem, half, mag;
    longint v;
    bit inexact, up, inRange;
    logic [2:0] rmEff;
    logic [31:0] satPos, satNeg;
    neg = x[31];
    satPos = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    satNeg = sgn ? 32'h8000_0000 : 32'h0000_0000;
    if (x[30:23] == FP_EXP_INF) begin
      res = (x[22:0] != 0 || !neg) ? satPos : satNeg;
      flg = 2'b10;
      lat = 1;
      return;
    end
    ex  = (x[30:23] == 0) ? (1 - FP_BIAS) : (int'(x[30:23]) - FP_BIAS);
    sig = {40'd0, (x[30:23] != 0), x[22:0]};
    if (ex > 31) begin
      res = neg ? satNeg : satPos;
      flg = 2'b10;
      lat = 1;
      return;
    end
    if (sig == 0) begin
      res = 32'd0;
      flg = 2'b00;
      lat = 2;
      return;
    end
    n   = (ex >= 23) ? (ex - 23) : (((23 - ex) > 25) ? 25 : (23 - ex));
    lat = n + 2;
    if (ex >= 23) begin
      ip = sig << (ex - 23);
      inexact = 1'b0;
      cmp = -1;
    end else begin
      sh = 23 - ex;
      if (sh >= 40) begin
        ip = 0;
        inexact = 1'b1;
        cmp = -1;
      end else begin
        ip   = sig >> sh;
        rem  = sig - (ip << sh);
        half = 64'd1 << (sh - 1);
        inexact = (rem != 0);
        cmp = (rem < half) ? -1 : ((rem == half) ? 0 : 1);
      end
    end
    rmEff = (RM_EN && rm <= 3'd4) ? rm : 3'd1;
    case (rmEff)
      3'd0:    up = (cmp > 0) || (cmp == 0 && ip[0]);
      3'd2:    up = neg && inexact;
      3'd3:    up = !neg && inexact;
      3'd4:    up = (cmp >= 0);
      default: up = 1'b0;
    endcase
    mag = ip + longint'(up);
    v   = neg ? -longint'(mag) : longint'(mag);
    if (sgn) inRange = (v >= -64'sd2147483648) && (v <= 64'sd2147483647);
    else     inRange = (v >= 0) && (v <= 64'sd4294967295);
    if (!inRange) begin
      res = neg ? satNeg : satPos;
      flg = 2'b10;
    end else begin
      res = v[31:0];
      flg = {1'b0, inexact};
    end
  endfunction

  // ---------------- driver ----------------
  // Entered and left at 1 time unit after a rising edge, DUT in IDLE.
  task automatic runConv(input logic [31:0] x, input bit sgn, input logic [2:0] rm,
                         input int hold, output logic [31:0] obsRes,
                         output logic [1:0] obsFlg, output int obsLat);
    logic [31:0] eRes;
    logic [1:0]  eFlg;
    int          eLat;
    logic [33:0] e;
    int          lat;
    refModel(x, sgn, rm, eRes, eFlg, eLat);
    exp_q.push_back({eRes, eFlg});
    checkVal("ready_before_req", bus.o_ready, 1);
    bus.i_valid  = 1'b1;
    bus.i_x      = x;
    bus.i_signed = sgn;
    bus.i_rm     = rm;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 40) begin
      bus.i_ready = 1'($urandom_range(0, 1));  // ignored outside DONE
      @(posedge i_clk); #1;
      lat++;
    end
    bus.i_ready = 1'b0;
    obsRes = bus.o_result;
    obsFlg = bus.o_flags;
    obsLat = lat;
    e = exp_q.pop_front();
    if (!bus.o_valid) begin
      checkVal("valid_timeout", bus.o_valid, 1);
      return;
    end
    checkVal("result", bus.o_result, e[33:2]);
    checkVal("flags", bus.o_flags, e[1:0]);
    checkVal("latency", lat, eLat);
    for (int k = 0; k < hold; k++) begin
      if (k == 1) begin
        bus.i_valid = 1'b1;
        bus.i_x     = $urandom;
      end
      if (k == 3) bus.i_valid = 1'b0;
      @(posedge i_clk); #1;
      checkVal("hold_valid", bus.o_valid, 1);
      checkVal("hold_ready", bus.o_ready, 0);
      checkVal("hold_result", bus.o_result, e[33:2]);
      checkVal("hold_flags", bus.o_flags, e[1:0]);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.i_ready = 1'b0;
    checkVal("post_hs_valid", bus.o_valid, 0);
    checkVal("post_hs_ready", bus.o_ready, 1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] x;
    bit          sgn;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
  } dvec_t;

  dvec_t dirTab[19];

  initial begin
    logic [31:0] r;
    logic [1:0]  f;
    int          l;
    logic [31:0] x;

    dirTab[0]  = '{32'h40490FDB, 1'b1, 3'd0, 32'h0000_0003, 2'b01, 24};
    dirTab[1]  = '{32'hCF000000, 1'b1, 3'd1, 32'h8000_0000, 2'b00, 10};
    dirTab[2]  = '{32'h4F000000, 1'b1, 3'd1, 32'h7FFF_FFFF, 2'b10, 10};
    dirTab[3]  = '{32'h4F000000, 1'b0, 3'd1, 32'h8000_0000, 2'b00, 10};
    dirTab[4]  = '{32'h7FC00000, 1'b1, 3'd0, 32'h7FFF_FFFF, 2'b10, 1};
    dirTab[5]  = '{32'hFF800000, 1'b0, 3'd1, 32'h0000_0000, 2'b10, 1};
    dirTab[6]  = '{32'h40200000, 1'b1, 3'd0, 32'h0000_0002, 2'b01, 24};
    dirTab[7]  = '{32'h40200000, 1'b1, 3'd4, RM_EN ? 32'h3 : 32'h2, 2'b01, 24};
    dirTab[8]  = '{32'h40200000, 1'b1, 3'd3, RM_EN ? 32'h3 : 32'h2, 2'b01, 24};
    dirTab[9]  = '{32'h40200000, 1'b1, 3'd1, 32'h0000_0002, 2'b01, 24};
    dirTab[10] = '{32'hC0200000, 1'b1, 3'd2, RM_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFE, 2'b01, 24};
    dirTab[11] = '{32'hBE99999A, 1'b0, 3'd1, 32'h0000_0000, 2'b01, 27};
    dirTab[12] = '{32'h00000000, 1'b1, 3'd0, 32'h0000_0000, 2'b00, 2};
    dirTab[13] = '{32'h3F800000, 1'b1, 3'd5, 32'h0000_0001, 2'b00, 25};
    dirTab[14] = '{32'h80000001, 1'b1, 3'd3, 32'h0000_0000, 2'b01, 27};
    dirTab[15] = '{32'h4F800000, 1'b0, 3'd1, 32'hFFFF_FFFF, 2'b10, 1};
    dirTab[16] = '{32'h3F000000, 1'b1, 3'd0, 32'h0000_0000, 2'b01, 26};
    dirTab[17] = '{32'h4F7FFFFF, 1'b0, 3'd1, 32'hFFFF_FF00, 2'b00, 10};
    dirTab[18] = '{32'hCF000001, 1'b1, 3'd1, 32'h8000_0000, 2'b10, 10};

    bus.i_valid  = 1'b0;
    bus.i_x      = '0;
    bus.i_signed = 1'b0;
    bus.i_rm     = '0;
    bus.i_ready  = 1'b0;

    // Reset values
    repeat (2) @(posedge i_clk);
    #1;
    checkVal("rst_valid", bus.o_valid, 0);
    checkVal("rst_ready", bus.o_ready, 1);
    checkVal("rst_result", bus.o_result, 0);
    checkVal("rst_flags", bus.o_flags, 0);
    checkVal("rst_state", dbg.state, CVT_IDLE);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed, each held in DONE for 5 cycles with an ignored request pulse
    foreach (dirTab[i]) begin
      runConv(dirTab[i].x, dirTab[i].sgn, dirTab[i].rm, 5, r, f, l);
      checkVal("dir_result", r, dirTab[i].res);
      checkVal("dir_flags", f, dirTab[i].flg);
      checkVal("dir_latency", l, dirTab[i].lat);
    end

    // Reset in the middle of a shift sequence
    bus.i_valid  = 1'b1;
    bus.i_x      = 32'h3F800000;
    bus.i_signed = 1'b1;
    bus.i_rm     = 3'd1;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkVal("mid_state", dbg.state, CVT_SHIFT);
    i_rst_n = 1'b0;
    #1;
    checkVal("mid_rst_valid", bus.o_valid, 0);
    checkVal("mid_rst_ready", bus.o_ready, 1);
    checkVal("mid_rst_result", bus.o_result, 0);
    checkVal("mid_rst_flags", bus.o_flags, 0);
    @(posedge i_clk); #1;
    checkVal("mid_rst_valid_edge", bus.o_valid, 0);
    checkVal("mid_rst_ready_edge", bus.o_ready, 1);
    i_rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge i_clk); #1;
      if (bus.o_valid) checkVal("no_result_after_rst", bus.o_valid, 0);
    end
    checkVal("idle_after_rst", dbg.state, CVT_IDLE);
    runConv(32'h3F800000, 1'b1, 3'd1, 1, r, f, l);
    checkVal("post_rst_result", r, 32'h1);

    // Randomized operands
    for (int t = 0; t < 250; t++) begin
      int cat;
      logic [7:0] ex;
      cat = $urandom_range(0, 9);
      case (cat)
        0:       ex = 8'hFF;
        1:       ex = 8'h00;
        2:       ex = 8'(150 + $urandom_range(0, 12));
        default: ex = 8'(100 + $urandom_range(0, 60));
      endcase
      x = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
      if (cat == 0 && $urandom_range(0, 3) == 0) x = FP_QNAN;
      if (cat == 1 && $urandom_range(0, 3) == 0) x[22:0] = '0;
      runConv(x, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom_range(1, 4), r, f, l);
    end

    checkVal("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
